// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the data-memory arbiter, its two requesters and Memoria64.
// The arbiter takes the slave view; requesters plus the memory model take the master view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              p0_req;
  logic              p1_req;
  logic              p0_we;
  logic              p1_we;
  logic              p0_lock;
  logic              p1_lock;
  logic [ADDR_W-1:0] p0_addr;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_done;
  logic              p1_done;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;
  logic              owner;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
    input  p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    output p0_done, p1_done, rdata, mem_addr, mem_wdata, mem_wr, busy, owner
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_lock, p1_lock,
    output p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    input  p0_done, p1_done, rdata, mem_addr, mem_wdata, mem_wr, busy, owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port data memory,
// with a per-owner lock so CPU read-modify-write sequences stay atomic.
module dmem_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  dmem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              lock_q, lock_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              winner;

  // A held lock lets the previous owner win outright; otherwise a tie goes to the other port.
  always_comb begin
    winner = 1'b0;
    if (lock_q && (owner_q ? bus.p1_req : bus.p0_req)) begin
      winner = owner_q;
    end else if (bus.p0_req && bus.p1_req) begin
      winner = ~owner_q;
    end else if (bus.p1_req) begin
      winner = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          owner_d = winner;
          we_d    = winner ? bus.p1_we    : bus.p0_we;
          addr_d  = winner ? bus.p1_addr  : bus.p0_addr;
          wdata_d = winner ? bus.p1_wdata : bus.p0_wdata;
          cnt_d   = 3'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = DONE;
        end else if (cnt_q == LAST_CNT) begin
          rdata_d = bus.mem_rdata;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        lock_d  = owner_q ? bus.p1_lock : bus.p0_lock;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner resets to port 1 so that port 0 wins the first tie after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      lock_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wr    = (state_q == ACCESS) && we_q;
  assign bus.p0_done   = (state_q == DONE) && !owner_q;
  assign bus.p1_done   = (state_q == DONE) && owner_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-port 64-bit data memory (`Memoria64`). Port 0 serves the CPU control FSM; port 1 serves the program/data loader (DMA-style). It serialises requests with round-robin fairness and drives the memory's address, data and write-enable lines. It honours a lock so the CPU's read-modify-write for sub-word stores (sb/sh/sw) is atomic. It sits between the `control`/datapath memory mux and `Memoria64`, replacing the direct address/`Wr` connection.

## Interface
- `ADDR_W`, default 64: width of address buses.
- `DATA_W`, default 64: width of data buses.
- `READ_LAT`, default 1, legal range 1..7: cycles from address presented to `mem_rdata` valid.

- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high; forces every register and output to its reset value immediately.
- `p0_req`, `p1_req` in 1 each: transaction request, held high until `pN_done`.
- `p0_we`, `p1_we` in 1 each: 1 = write, 0 = read; stable while `pN_req` is high.
- `p0_lock`, `p1_lock` in 1 each: keep the grant for this port's next transaction.
- `p0_addr`, `p1_addr` in `ADDR_W` each: byte address.
- `p0_wdata`, `p1_wdata` in `DATA_W` each: write data.
- `p0_done`, `p1_done` out 1 each: one-cycle completion pulse.
- `rdata` out `DATA_W`: read data of the last completed read; valid with `done`.
- `mem_addr` out `ADDR_W`: address to the memory (`raddress` and `waddress`).
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_wr` out 1: memory write enable.
- `mem_rdata` in `DATA_W`: memory read data.
- `busy` out 1: high in any state other than IDLE.
- `owner` out 1: port of the current or last grant.

## Operation
- The FSM has three states: IDLE, ACCESS and DONE.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner and latch its `we`, `addr` and `wdata` into `we_q`, `addr_q` and `wdata_q`.
  - Set `owner` to the winner and clear the latency counter `cnt`. Go to ACCESS.
- **Winner selection**
  - If only one port is requesting, that port wins.
  - If both ports request, the port not equal to `owner` wins (round-robin).
  - Exception: if `lock_q` is set, `owner` wins whenever it is requesting.
- **ACCESS**
  - `mem_addr` = `addr_q` and `mem_wdata` = `wdata_q`.
  - Write: `mem_wr` = 1 for exactly one cycle, then go to DONE.
  - Read: `mem_wr` = 0 and `cnt` increments each cycle. When `cnt` = `READ_LAT`-1, capture `mem_rdata` into `rdata` and go to DONE.
- **DONE**
  - Assert `pN_done` for `owner`; the other port's `done` stays 0.
  - Latch `lock_q` from `pN_lock` of `owner`. Return to IDLE.
- `mem_wr` is decoded only from state==ACCESS && `we_q`. It is never 1 outside ACCESS.
- A requester that sees `done` may keep `req` high to issue a new transaction. That request is sampled in the following IDLE cycle.
- The lock is taken when `owner`'s `lock` is high at DONE and cleared when it is low at a later DONE. While `lock_q` is set and `owner` is not requesting, the other port may be granted; that grant clears `lock_q` at its DONE.
- Outside ACCESS, `mem_addr` and `mem_wdata` hold the last latched values.

## Timing
- **Reset values:** state IDLE; `mem_wr` 0; `p0_done` and `p1_done` 0; `busy` 0; `owner` 1, so port 0 wins the first tie; `lock_q` 0; `addr_q`, `wdata_q` and `rdata` all 0.
- **Write latency:** request sampled in IDLE at cycle 0 → ACCESS with `mem_wr` 1 in cycle 1 → `done` in cycle 2.
- **Read latency:** `done` in cycle `READ_LAT`+1. `rdata` is valid from the `done` cycle until the next read completes.
- **Throughput:** minimum 3 cycles per write and `READ_LAT`+2 cycles per read, including the IDLE cycle.
- **Fairness:** with both ports requesting continuously and no lock, grants alternate 0,1,0,1.
- Requests arriving during ACCESS or DONE are only sampled in IDLE; none are lost as long as `req` is held.
- **Reset mid-transaction:** `mem_wr` drops asynchronously. No `done` is issued, and the partially completed access is abandoned.
- Dropping `req` before `done` is illegal; the arbiter completes the latched transaction regardless.

## Test plan
- **Single write from port 0:** `p0_req`=1, `we`=1, `addr`=0x10, `wdata`=0xDEADBEEF at cycle 0. Expect `mem_wr`=1 with `mem_addr`=0x10 only in cycle 1, `p0_done` in cycle 2, `p1_done` never.
- **Read with `READ_LAT`=3:** port 1 reads `addr` 0x20 while the memory model returns 0x1234 three cycles after the address. Expect `p1_done` in cycle 4 with `rdata`=0x1234 and `mem_wr` 0 throughout.
- **Contention after reset:** both ports request writes from cycle 0. Expect grant order 0,1,0,1 over four transactions, `done` pulses in cycles 2, 5, 8 and 11, and `owner` toggling each time.
- **Lock:** port 0 does read then write (`lock`=1 on the read, 0 on the write) while port 1 requests continuously. Expect port 0's write granted before port 1, then port 1 granted next.
- **Reset mid-write:** assert `reset` during the ACCESS cycle of a write. Expect `mem_wr` 0 within the same cycle, state IDLE, `busy` 0, no `done`, and correct operation on the first transaction after release.
- **Back-to-back reads from port 0:** hold `req`=1 with alone requests. Expect a new grant in the IDLE cycle after each `done` and `busy` low only in those IDLE cycles.
